// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master native memory bus arbiter.
// Holds the bus field widths, FSM state encodings, master index constants,
// the default read data returned on a timed-out transaction and a small
// one-hot helper.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // FSM state encoding, kept as plain constants for compatibility with
  // older tools that handle enums poorly.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Master indices: the CPU core and the secondary loader/DMA master.
  localparam logic M_CPU = 1'b0;
  localparam logic M_AUX = 1'b1;

  localparam logic [DATA_W-1:0] DEFAULT_TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-input round-robin winner select (purely combinational).
// Ports:
//   req0, req1 : request lines from master 0 and master 1
//   last_grant : index of the master that owned the previous transaction
//   sel        : index of the winning master (valid when any_req is high)
//   any_req    : at least one master is requesting
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic sel,
  output logic any_req
);

  // A sole requester always wins; on a tie the master that did not own
  // the previous transaction goes next, which gives strict alternation.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) begin
      sel = ~last_grant;
    end else if (req1) begin
      sel = M_AUX;
    end else begin
      sel = M_CPU;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one picorv32-style native memory port between
// the CPU (m0) and a secondary master (m1). A grant is held for one whole
// transaction, and a watchdog force-completes any request the slave never
// acknowledges so neither master can hang.
// Ports:
//   clk, resetn             : clock and asynchronous ACTIVE-HIGH reset
//   mX_valid/instr/addr/wdata/wstrb : master requests (wstrb==0 means read)
//   mX_ready, mX_rdata      : registered completion pulse and read data
//   s_valid/instr/addr/wdata/wstrb  : registered request toward the slave
//   s_ready, s_rdata        : slave completion and read data
//   grant                   : one-hot owner of the current transaction
//   timeout_err             : one-cycle pulse on forced completion
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int                TIMEOUT      = 255,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              m0_valid,
  input  logic              m0_instr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wstrb,
  output logic              m0_ready,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_valid,
  input  logic              m1_instr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wstrb,
  output logic              m1_ready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_valid,
  output logic              s_instr,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic [STRB_W-1:0] s_wstrb,
  input  logic              s_ready,
  input  logic [DATA_W-1:0] s_rdata,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic       last_grant;
  logic       cur;
  logic       is_read;
  logic [7:0] cnt;

  logic              sel;
  logic              any_req;
  logic              sel_instr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STRB_W-1:0] sel_wstrb;

  rr_arb2 u_rr_arb2 (
    .req0       (m0_valid),
    .req1       (m1_valid),
    .last_grant (last_grant),
    .sel        (sel),
    .any_req    (any_req)
  );

  // Request fields of whichever master wins the current arbitration.
  always_comb begin
    sel_instr = sel ? m1_instr : m0_instr;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    sel_wstrb = sel ? m1_wstrb : m0_wstrb;
  end

  // Main FSM. The read/write flag is kept separately because s_wstrb is
  // cleared on slave completion while rdata still needs the distinction.
  // The DONE cycle gives the finished master a chance to drop valid before
  // the next arbitration, so a stale request is never granted twice.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state       <= ST_IDLE;
      last_grant  <= M_AUX;
      cur         <= M_CPU;
      is_read     <= 1'b0;
      cnt         <= '0;
      m0_ready    <= 1'b0;
      m1_ready    <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      s_valid     <= 1'b0;
      s_instr     <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_wstrb     <= '0;
      grant       <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            s_valid    <= 1'b1;
            s_instr    <= sel_instr;
            s_addr     <= sel_addr;
            s_wdata    <= sel_wdata;
            s_wstrb    <= sel_wstrb;
            is_read    <= (sel_wstrb == '0);
            grant      <= onehot2(sel);
            last_grant <= sel;
            cur        <= sel;
            cnt        <= '0;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 8'd1;
          if (s_ready) begin
            s_valid <= 1'b0;
            s_wstrb <= '0;
            state   <= ST_DONE;
            if (cur == M_AUX) begin
              m1_ready <= 1'b1;
              if (is_read) m1_rdata <= s_rdata;
            end else begin
              m0_ready <= 1'b1;
              if (is_read) m0_rdata <= s_rdata;
            end
          end else if (cnt == CNT_LAST) begin
            s_valid     <= 1'b0;
            timeout_err <= 1'b1;
            state       <= ST_DONE;
            if (cur == M_AUX) begin
              m1_ready <= 1'b1;
              if (is_read) m1_rdata <= TIMEOUT_DATA;
            end else begin
              m0_ready <= 1'b1;
              if (is_read) m0_rdata <= TIMEOUT_DATA;
            end
          end
        end
        ST_DONE: begin
          m0_ready    <= 1'b0;
          m1_ready    <= 1'b0;
          timeout_err <= 1'b0;
          grant       <= '0;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. A table of transactions drives
// both masters and a scripted slave, checking grant, forwarded fields,
// completion timing, read data of both masters and the timeout pulse.
// Hand-written sequences cover the reset state and a mid-transaction reset.
module tb_mem_bus_arbiter;

  localparam int TB_TIMEOUT = 4;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks;
  int errors;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  w0;
    logic        i0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [3:0]  w1;
    logic        i1;
    int          ready_cyc;
    logic [31:0] srd;
    logic [1:0]  exp_grant;
    int          exp_ready_cyc;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
    logic        exp_to;
  } vec_t;

  vec_t vecs[12];

  mem_bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .m0_valid    (m0_valid),
    .m0_instr    (m0_instr),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_instr    (m1_instr),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_instr     (s_instr),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t make_vec(
    logic [1:0] req,
    logic [31:0] a0, logic [31:0] d0, logic [3:0] w0, logic i0,
    logic [31:0] a1, logic [31:0] d1, logic [3:0] w1, logic i1,
    int rc, logic [31:0] srd, logic [1:0] eg, int erc,
    logic [31:0] er0, logic [31:0] er1, logic eto);
    vec_t v;
    v.req = req;
    v.a0 = a0; v.d0 = d0; v.w0 = w0; v.i0 = i0;
    v.a1 = a1; v.d1 = d1; v.w1 = w1; v.i1 = i1;
    v.ready_cyc = rc;
    v.srd = srd;
    v.exp_grant = eg;
    v.exp_ready_cyc = erc;
    v.exp_r0 = er0;
    v.exp_r1 = er1;
    v.exp_to = eto;
    return v;
  endfunction

  // One comparison: bumps the counters and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // Runs one transaction. Called at #1 after a clock edge with the DUT idle;
  // returns at #1 after the edge that brings the DUT back to idle.
  task automatic applyStimulus(input vec_t v, input int idx);
    logic        sel_m1;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_instr;
    int          cyc;
    int          sv_cnt;
    logic        got;
    string       p;
    p = $sformatf("v%0d", idx);
    sel_m1    = v.exp_grant[1];
    exp_addr  = sel_m1 ? v.a1 : v.a0;
    exp_wdata = sel_m1 ? v.d1 : v.d0;
    exp_wstrb = sel_m1 ? v.w1 : v.w0;
    exp_instr = sel_m1 ? v.i1 : v.i0;

    m0_valid = v.req[0]; m0_addr = v.a0; m0_wdata = v.d0; m0_wstrb = v.w0; m0_instr = v.i0;
    m1_valid = v.req[1]; m1_addr = v.a1; m1_wdata = v.d1; m1_wstrb = v.w1; m1_instr = v.i1;
    s_ready = 1'b0;
    @(posedge clk); #1;

    checkOutput({p, "_s_valid_c1"}, {31'd0, s_valid}, 32'd1);
    checkOutput({p, "_grant"}, {30'd0, grant}, {30'd0, v.exp_grant});
    checkOutput({p, "_s_addr"}, s_addr, exp_addr);
    checkOutput({p, "_s_wdata"}, s_wdata, exp_wdata);
    checkOutput({p, "_s_wstrb"}, {28'd0, s_wstrb}, {28'd0, exp_wstrb});
    checkOutput({p, "_s_instr"}, {31'd0, s_instr}, {31'd0, exp_instr});

    cyc = 1;
    sv_cnt = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      if (s_valid) sv_cnt++;
      s_ready = (v.ready_cyc == cyc);
      s_rdata = v.srd;
      @(posedge clk); #1;
      cyc++;
      if (m0_ready || m1_ready) got = 1'b1;
    end
    s_ready = 1'b0;

    checkOutput({p, "_ready_seen"}, {31'd0, got}, 32'd1);
    checkOutput({p, "_ready_cycle"}, cyc, v.exp_ready_cyc);
    checkOutput({p, "_s_valid_cycles"}, sv_cnt, v.exp_ready_cyc - 1);
    checkOutput({p, "_m0_ready"}, {31'd0, m0_ready}, {31'd0, ~sel_m1});
    checkOutput({p, "_m1_ready"}, {31'd0, m1_ready}, {31'd0, sel_m1});
    checkOutput({p, "_m0_rdata"}, m0_rdata, v.exp_r0);
    checkOutput({p, "_m1_rdata"}, m1_rdata, v.exp_r1);
    checkOutput({p, "_timeout_err"}, {31'd0, timeout_err}, {31'd0, v.exp_to});
    checkOutput({p, "_s_valid_done"}, {31'd0, s_valid}, 32'd0);
    if (!v.exp_to) checkOutput({p, "_s_wstrb_done"}, {28'd0, s_wstrb}, 32'd0);

    @(posedge clk); #1;
    checkOutput({p, "_grant_idle"}, {30'd0, grant}, 32'd0);
    checkOutput({p, "_ready_drop"}, {30'd0, m1_ready, m0_ready}, 32'd0);
    checkOutput({p, "_timeout_drop"}, {31'd0, timeout_err}, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;

    // Tie fairness from reset, then write, read, timeout and corner cases.
    vecs[0]  = make_vec(2'b11, 32'h20, 0, 0, 1, 32'h1000_0004, 0, 0, 0, 1, 32'hA000_0000, 2'b01, 2, 32'hA000_0000, 32'h0, 0);
    vecs[1]  = make_vec(2'b11, 32'h20, 0, 0, 1, 32'h1000_0004, 0, 0, 0, 1, 32'hA000_0001, 2'b10, 2, 32'hA000_0000, 32'hA000_0001, 0);
    vecs[2]  = make_vec(2'b11, 32'h20, 0, 0, 1, 32'h1000_0004, 0, 0, 0, 1, 32'hA000_0002, 2'b01, 2, 32'hA000_0002, 32'hA000_0001, 0);
    vecs[3]  = make_vec(2'b11, 32'h20, 0, 0, 1, 32'h1000_0004, 0, 0, 0, 1, 32'hA000_0003, 2'b10, 2, 32'hA000_0002, 32'hA000_0003, 0);
    vecs[4]  = make_vec(2'b11, 32'h20, 0, 0, 1, 32'h1000_0004, 0, 0, 0, 1, 32'hA000_0004, 2'b01, 2, 32'hA000_0004, 32'hA000_0003, 0);
    vecs[5]  = make_vec(2'b11, 32'h20, 0, 0, 1, 32'h1000_0004, 0, 0, 0, 1, 32'hA000_0005, 2'b10, 2, 32'hA000_0004, 32'hA000_0005, 0);
    vecs[6]  = make_vec(2'b10, 32'h0, 0, 0, 0, 32'h1000_0000, 32'h41, 4'b0001, 0, 2, 32'h7777_7777, 2'b10, 3, 32'hA000_0004, 32'hA000_0005, 0);
    vecs[7]  = make_vec(2'b01, 32'h10, 0, 0, 0, 32'h0, 0, 0, 0, 3, 32'h1234_5678, 2'b01, 4, 32'h1234_5678, 32'hA000_0005, 0);
    vecs[8]  = make_vec(2'b01, 32'h44, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h5555_5555, 2'b01, 5, 32'hDEAD_BEEF, 32'hA000_0005, 1);
    vecs[9]  = make_vec(2'b01, 32'h48, 0, 0, 0, 32'h0, 0, 0, 0, 4, 32'hCAFE_F00D, 2'b01, 5, 32'hCAFE_F00D, 32'hA000_0005, 0);
    vecs[10] = make_vec(2'b10, 32'h0, 0, 0, 0, 32'h1000_0000, 32'h42, 4'b1111, 0, 0, 32'h6666_6666, 2'b10, 5, 32'hCAFE_F00D, 32'hA000_0005, 1);
    vecs[11] = make_vec(2'b10, 32'h0, 0, 0, 0, 32'h100, 0, 0, 1, 1, 32'h0000_0013, 2'b10, 2, 32'hCAFE_F00D, 32'h0000_0013, 0);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_valid", {31'd0, s_valid}, 32'd0);
    checkOutput("rst_grant", {30'd0, grant}, 32'd0);
    checkOutput("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    checkOutput("rst_m0_rdata", m0_rdata, 32'd0);
    checkOutput("rst_m1_rdata", m1_rdata, 32'd0);
    checkOutput("rst_s_addr", s_addr, 32'd0);
    checkOutput("rst_s_wdata", s_wdata, 32'd0);
    checkOutput("rst_s_wstrb_instr", {27'd0, s_instr, s_wstrb}, 32'd0);
    checkOutput("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
    resetn = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i], i);
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    // Mid-transaction reset: outputs must clear without any clock edge.
    m0_valid = 1'b1; m0_addr = 32'h80; m0_wstrb = 4'b0000; m0_instr = 1'b0;
    @(posedge clk); #1;
    checkOutput("mid_s_valid_before", {31'd0, s_valid}, 32'd1);
    #2;
    resetn = 1'b1;
    #1;
    checkOutput("mid_s_valid_async", {31'd0, s_valid}, 32'd0);
    checkOutput("mid_grant_async", {30'd0, grant}, 32'd0);
    checkOutput("mid_ready_async", {30'd0, m1_ready, m0_ready}, 32'd0);
    checkOutput("mid_m0_rdata_async", m0_rdata, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b0;
    m0_valid = 1'b1; m0_addr = 32'h84;
    m1_valid = 1'b1; m1_addr = 32'h1000_0008; m1_wstrb = 4'b0000;
    @(posedge clk); #1;
    checkOutput("post_rst_tie_grant", {30'd0, grant}, 32'd1);
    checkOutput("post_rst_tie_addr", s_addr, 32'h84);
    m0_valid = 1'b0;
    m1_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
